// File: rtl/pulse_scheduler.sv
// pulse_scheduler
//   Sequences one burst of synchronizing pulses across NCH channels per
//   accepted start request. Per-channel delay/width/enable are latched on the
//   start, the burst length is derived from the enabled channels, every
//   channel window is timed from one shared counter, and re-triggering is
//   held off for GUARD cycles after the burst ends.
//
// Ports
//   ps_clk    system clock
//   ps_rst_n  asynchronous active-low reset
//   ps_start  start request level (only a rising transition is used)
//   ps_en     per-channel enable
//   ps_delay  channel i delay at [i*CW +: CW], in cycles
//   ps_width  channel i width at [i*CW +: CW], in cycles
//   ps_out    registered pulse outputs
//   ps_busy   high while calculating, running or in guard hold-off
//   ps_done   one-cycle pulse at burst end
//   ps_err    one-cycle pulse when an accepted start yields zero duration
module pulse_scheduler #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = 16,
  parameter int unsigned GUARD = 1000
) (
  input  logic              ps_clk,
  input  logic              ps_rst_n,
  input  logic              ps_start,
  input  logic [NCH-1:0]    ps_en,
  input  logic [NCH*CW-1:0] ps_delay,
  input  logic [NCH*CW-1:0] ps_width,
  output logic [NCH-1:0]    ps_out,
  output logic              ps_busy,
  output logic              ps_done,
  output logic              ps_err
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int unsigned TW = CW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_RUN,
    ST_GUARD
  } state_t;

  state_t          state_q, state_nx;
  logic            s_d;
  logic            rise;

  logic [NCH-1:0]  en_q;
  logic [CW-1:0]   dly_q [NCH];
  logic [CW-1:0]   wid_q [NCH];
  logic [TW-1:0]   end_w [NCH];

  logic [IW-1:0]   idx_q;
  logic [TW-1:0]   total_q;
  logic [TW-1:0]   total_nx;
  logic [TW-1:0]   t_q;
  logic [GW-1:0]   gcnt_q;

  logic            calc_last;
  logic            cur_valid;
  logic            t_hit;

  logic [NCH-1:0]  out_nx;
  logic            busy_nx;
  logic            done_nx;
  logic            err_nx;

  assign rise      = ps_start & ~s_d;
  assign calc_last = (idx_q == IW'(NCH - 1));
  assign t_hit     = (t_q == total_q);

  // Channel end times are one bit wider than the fields, so delay+width
  // can never wrap.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      end_w[i] = {1'b0, dly_q[i]} + {1'b0, wid_q[i]};
    end
  end

  // Running maximum including the channel examined this cycle; used both to
  // update total and to decide error vs. run on the last channel.
  always_comb begin
    cur_valid = en_q[idx_q] & (wid_q[idx_q] != '0);
    total_nx  = total_q;
    if (cur_valid && (end_w[idx_q] > total_q)) begin
      total_nx = end_w[idx_q];
    end
  end

  // State register
  always_ff @(posedge ps_clk or negedge ps_rst_n) begin
    if (!ps_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:  if (rise) state_nx = ST_CALC;
      ST_CALC:  if (calc_last) state_nx = (total_nx == '0) ? ST_IDLE : ST_RUN;
      ST_RUN:   if (t_hit) state_nx = ST_GUARD;
      ST_GUARD: if (gcnt_q == '0) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    out_nx  = '0;
    done_nx = 1'b0;
    err_nx  = 1'b0;
    busy_nx = (state_nx != ST_IDLE);
    if (state_q == ST_RUN) begin
      if (t_hit) begin
        done_nx = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NCH; i++) begin
          out_nx[i] = en_q[i] & (wid_q[i] != '0) &
                      (t_q >= {1'b0, dly_q[i]}) & (t_q < end_w[i]);
        end
      end
    end
    if ((state_q == ST_CALC) && calc_last && (total_nx == '0)) begin
      err_nx = 1'b1;
    end
  end

  always_ff @(posedge ps_clk or negedge ps_rst_n) begin
    if (!ps_rst_n) begin
      ps_out  <= '0;
      ps_busy <= 1'b0;
      ps_done <= 1'b0;
      ps_err  <= 1'b0;
    end else begin
      ps_out  <= out_nx;
      ps_busy <= busy_nx;
      ps_done <= done_nx;
      ps_err  <= err_nx;
    end
  end

  // Datapath: edge detector, shadow configuration, duration and timers.
  // s_d resets high so a start already asserted at reset release is ignored.
  always_ff @(posedge ps_clk or negedge ps_rst_n) begin
    if (!ps_rst_n) begin
      s_d     <= 1'b1;
      en_q    <= '0;
      idx_q   <= '0;
      total_q <= '0;
      t_q     <= '0;
      gcnt_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        dly_q[i] <= '0;
        wid_q[i] <= '0;
      end
    end else begin
      s_d <= ps_start;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            en_q    <= ps_en;
            total_q <= '0;
            idx_q   <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
              dly_q[i] <= ps_delay[i*CW +: CW];
              wid_q[i] <= ps_width[i*CW +: CW];
            end
          end
        end
        ST_CALC: begin
          total_q <= total_nx;
          idx_q   <= idx_q + IW'(1);
          if (calc_last) begin
            t_q <= '0;
          end
        end
        ST_RUN: begin
          t_q <= t_q + TW'(1);
          if (t_hit) begin
            gcnt_q <= GW'(GUARD - 1);
          end
        end
        ST_GUARD: begin
          if (gcnt_q != '0) begin
            gcnt_q <= gcnt_q - GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Testbench for pulse_scheduler: two instances (CW=16 and CW=8), expected
// events derived from configuration and start edge, checked by a monitor.
module tb_pulse_scheduler;

  localparam int NCH = 4;
  localparam int GRD = 8;

  logic        ps_clk = 1'b0;
  logic        ps_rst_n = 1'b0;

  logic        ps_start = 1'b0;
  logic [3:0]  ps_en = '0;
  logic [63:0] ps_delay = '0;
  logic [63:0] ps_width = '0;
  logic [3:0]  ps_out;
  logic        ps_busy, ps_done, ps_err;

  logic        start8 = 1'b0;
  logic [3:0]  en8 = '0;
  logic [31:0] dly8 = '0;
  logic [31:0] wid8 = '0;
  logic [3:0]  out8;
  logic        busy8, done8, err8;

  pulse_scheduler #(.NCH(4), .CW(16), .GUARD(8)) dut (
    .ps_clk(ps_clk), .ps_rst_n(ps_rst_n), .ps_start(ps_start),
    .ps_en(ps_en), .ps_delay(ps_delay), .ps_width(ps_width),
    .ps_out(ps_out), .ps_busy(ps_busy), .ps_done(ps_done), .ps_err(ps_err)
  );

  pulse_scheduler #(.NCH(4), .CW(8), .GUARD(8)) dut8 (
    .ps_clk(ps_clk), .ps_rst_n(ps_rst_n), .ps_start(start8),
    .ps_en(en8), .ps_delay(dly8), .ps_width(wid8),
    .ps_out(out8), .ps_busy(busy8), .ps_done(done8), .ps_err(err8)
  );

  always #5 ps_clk = ~ps_clk;

  int cyc = 0;
  always @(posedge ps_clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int ch;
    int start;
    int width;
  } pulse_t;

  // Scoreboard queues (cycle numbers of expected events)
  int     q_brise[$], q_bfall[$], q_done[$], q_err[$];
  pulse_t q_out[$];
  int     q8_brise[$], q8_bfall[$], q8_done[$];
  pulse_t q8_out[$];

  function automatic int pending();
    return q_brise.size() + q_bfall.size() + q_done.size() + q_err.size() +
           q_out.size() + q8_brise.size() + q8_bfall.size() + q8_done.size() +
           q8_out.size();
  endfunction

  // Monitor for the CW=16 instance
  logic [3:0] out_p = '0;
  logic       busy_p = 1'b0;
  int         rise_c [4];
  int         pend_w [4];

  always @(negedge ps_clk) begin
    if (!ps_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rise_c[i] = 0;
        pend_w[i] = 0;
      end
    end else begin
      if (ps_busy && !busy_p) begin
        if (q_brise.size() > 0) check_eq("busy_rise", cyc, q_brise.pop_front());
        else check_eq("busy_rise_extra", 1, 0);
      end
      if (!ps_busy && busy_p) begin
        if (q_bfall.size() > 0) check_eq("busy_fall", cyc, q_bfall.pop_front());
        else check_eq("busy_fall_extra", 1, 0);
      end
      if (ps_done) begin
        if (q_done.size() > 0) check_eq("done", cyc, q_done.pop_front());
        else check_eq("done_extra", 1, 0);
      end
      if (ps_err) begin
        if (q_err.size() > 0) check_eq("err", cyc, q_err.pop_front());
        else check_eq("err_extra", 1, 0);
      end
      for (int i = 0; i < 4; i++) begin
        if (ps_out[i] && !out_p[i]) begin
          int jf;
          jf = -1;
          for (int j = 0; j < q_out.size(); j++) begin
            if (jf < 0 && q_out[j].ch == i) jf = j;
          end
          if (jf >= 0) begin
            check_eq($sformatf("out%0d_start", i), cyc, q_out[jf].start);
            pend_w[i] = q_out[jf].width;
            q_out.delete(jf);
          end else begin
            check_eq($sformatf("out%0d_extra", i), 1, 0);
            pend_w[i] = 0;
          end
          rise_c[i] = cyc;
        end
        if (!ps_out[i] && out_p[i]) begin
          check_eq($sformatf("out%0d_width", i), cyc - rise_c[i], pend_w[i]);
        end
      end
    end
    out_p  = ps_rst_n ? ps_out : '0;
    busy_p = ps_rst_n ? ps_busy : 1'b0;
  end

  // Monitor for the CW=8 instance
  logic [3:0] out8_p = '0;
  logic       busy8_p = 1'b0;
  int         rise8_c = 0;
  int         pend8_w = 0;

  always @(negedge ps_clk) begin
    if (ps_rst_n) begin
      if (busy8 && !busy8_p) begin
        if (q8_brise.size() > 0) check_eq("c8_busy_rise", cyc, q8_brise.pop_front());
        else check_eq("c8_busy_rise_extra", 1, 0);
      end
      if (!busy8 && busy8_p) begin
        if (q8_bfall.size() > 0) check_eq("c8_busy_fall", cyc, q8_bfall.pop_front());
        else check_eq("c8_busy_fall_extra", 1, 0);
      end
      if (done8) begin
        if (q8_done.size() > 0) check_eq("c8_done", cyc, q8_done.pop_front());
        else check_eq("c8_done_extra", 1, 0);
      end
      if (err8) check_eq("c8_err_extra", 1, 0);
      if ((out8[3:1] & ~out8_p[3:1]) != 3'b000) check_eq("c8_out_hi_extra", 1, 0);
      if (out8[0] && !out8_p[0]) begin
        if (q8_out.size() > 0) begin
          pulse_t e;
          e = q8_out.pop_front();
          check_eq("c8_out0_start", cyc, e.start);
          pend8_w = e.width;
        end else begin
          check_eq("c8_out0_extra", 1, 0);
          pend8_w = 0;
        end
        rise8_c = cyc;
      end
      if (!out8[0] && out8_p[0]) check_eq("c8_out0_width", cyc - rise8_c, pend8_w);
    end
    out8_p  = ps_rst_n ? out8 : '0;
    busy8_p = ps_rst_n ? busy8 : 1'b0;
  end

  // Drive a rise on the CW=16 instance and push the events it must produce.
  task automatic start_burst(input logic [3:0] en, input logic [63:0] dly,
                             input logic [63:0] wid);
    int k, tot, d, w;
    @(negedge ps_clk);
    ps_en = en; ps_delay = dly; ps_width = wid; ps_start = 1'b1;
    k = cyc + 1;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      d = int'(dly[i*16 +: 16]);
      w = int'(wid[i*16 +: 16]);
      if (en[i] && w != 0) begin
        if (d + w > tot) tot = d + w;
        q_out.push_back('{ch: i, start: k + NCH + d + 1, width: w});
      end
    end
    q_brise.push_back(k);
    if (tot > 0) begin
      q_done.push_back(k + NCH + tot + 1);
      q_bfall.push_back(k + NCH + tot + 1 + GRD);
    end else begin
      q_err.push_back(k + NCH);
      q_bfall.push_back(k + NCH);
    end
  endtask

  task automatic start8_burst(input int d, input int w);
    int k;
    @(negedge ps_clk);
    en8 = 4'b0001; dly8 = {24'd0, d[7:0]}; wid8 = {24'd0, w[7:0]}; start8 = 1'b1;
    k = cyc + 1;
    q8_out.push_back('{ch: 0, start: k + NCH + d + 1, width: w});
    q8_brise.push_back(k);
    q8_done.push_back(k + NCH + d + w + 1);
    q8_bfall.push_back(k + NCH + d + w + 1 + GRD);
  endtask

  task automatic release_start();
    @(negedge ps_clk);
    ps_start = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic wait_quiet(input int limit);
    int n;
    n = 0;
    while (n < limit && (ps_busy || busy8 || pending() != 0)) begin
      @(negedge ps_clk);
      n++;
    end
    check_eq("quiet_in_time", (n < limit) ? 1 : 0, 1);
    repeat (4) @(negedge ps_clk);
  endtask

  task automatic clear_expect();
    q_brise.delete(); q_bfall.delete(); q_done.delete(); q_err.delete();
    q_out.delete();
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge ps_clk);
    check_eq("rst_out", ps_out, 0);
    check_eq("rst_busy", ps_busy, 0);
    check_eq("rst_done", ps_done, 0);
    check_eq("rst_err", ps_err, 0);
    check_eq("rst_out8", out8, 0);
    #1 ps_rst_n = 1'b1;
    repeat (3) @(negedge ps_clk);

    // Single channel d=3 w=5
    start_burst(4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, {16'd0, 16'd0, 16'd0, 16'd5});
    release_start();
    wait_quiet(100);

    // Four channels, ch3 width 0 excluded; total 11
    start_burst(4'b1111, {16'd4, 16'd10, 16'd2, 16'd0}, {16'd0, 16'd1, 16'd4, 16'd4});
    release_start();
    wait_quiet(100);

    // Held start, then extra rises during RUN and GUARD (total 103)
    start_burst(4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, {16'd0, 16'd0, 16'd0, 16'd100});
    repeat (100) @(negedge ps_clk);
    ps_start = 1'b0;
    repeat (3) @(negedge ps_clk);
    ps_start = 1'b1;
    repeat (2) @(negedge ps_clk);
    ps_start = 1'b0;
    repeat (6) @(negedge ps_clk);
    ps_start = 1'b1;
    repeat (2) @(negedge ps_clk);
    ps_start = 1'b0;
    wait_quiet(200);

    // Zero-duration configurations
    start_burst(4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, {16'd5, 16'd6, 16'd7, 16'd8});
    release_start();
    wait_quiet(50);
    start_burst(4'b1111, {16'd1, 16'd2, 16'd3, 16'd4}, '0);
    release_start();
    wait_quiet(50);

    // Reset mid-RUN with start held high through reset release
    start_burst(4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, {16'd0, 16'd0, 16'd0, 16'd5});
    repeat (10) @(negedge ps_clk);
    #2 ps_rst_n = 1'b0;
    #1;
    check_eq("midrst_out", ps_out, 0);
    check_eq("midrst_busy", ps_busy, 0);
    check_eq("midrst_done", ps_done, 0);
    check_eq("midrst_err", ps_err, 0);
    clear_expect();
    repeat (3) @(negedge ps_clk);
    #1 ps_rst_n = 1'b1;
    repeat (20) @(negedge ps_clk);
    check_eq("held_start_no_busy", ps_busy, 0);
    release_start();
    start_burst(4'b0101, {16'd0, 16'd7, 16'd0, 16'd0}, {16'd0, 16'd2, 16'd0, 16'd3});
    release_start();
    wait_quiet(100);

    // CW=8, d=w=255: total 510 without wrap
    start8_burst(255, 255);
    release_start();
    wait_quiet(700);

    check_eq("leftover_expect", pending(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
